alu_op_sequencer: RTL and testbench

Front-end controller for the 6-bit ALU datapath. It collects operand A, operand B and an opcode from a single shared data bus on successive load pulses, drives them to the ALU, waits a fixed datapath latency, then captures and holds the result. It sits between the debounced board inputs (switches plus a load button) and the ALU operation units (AND/OR/ADD/SUB/...), and exposes its state for LED display.

---
 rtl/alu_op_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Operand/opcode sequencer for the ALU datapath: loads A, B and opcode from a shared
// bus on load edges, runs the datapath for LAT cycles, then captures and holds the result.
module alu_op_sequencer #(
   parameter int unsigned WIDTH   = 6,
   parameter int unsigned OPW     = 3,
   parameter int unsigned NUM_OPS = 5,
   parameter int unsigned LAT     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   input  logic [WIDTH-1:0] alu_y,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [OPW-1:0]   op_sel,
   output logic             op_valid,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             err,
   output logic [2:0]       state
);

   localparam int unsigned CntW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CntW-1:0] CntInit = CntW'(LAT - 1);

   typedef enum logic [2:0] {
      StA    = 3'd0,
      StB    = 3'd1,
      StOp   = 3'd2,
      StExec = 3'd3,
      StDone = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             load_q;
   logic             ld;
   logic             op_legal;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [OPW-1:0]   op_sel_q, op_sel_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             err_q, err_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   assign ld       = load & ~load_q;
   assign op_legal = 32'(data_in[OPW-1:0]) < NUM_OPS;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StA;
         load_q         <= 1'b0;
         op_a_q         <= '0;
         op_b_q         <= '0;
         op_sel_q       <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         load_q         <= load;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         op_sel_q       <= op_sel_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         err_q          <= err_d;
         cnt_q          <= cnt_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      op_sel_d       = op_sel_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      err_d          = err_q;
      cnt_d          = cnt_q;
      case (state_q)
         StA: begin
            if (ld) begin
               op_a_d  = data_in;
               state_d = StB;
            end
         end
         StB: begin
            if (ld) begin
               op_b_d  = data_in;
               state_d = StOp;
            end
         end
         StOp: begin
            if (ld) begin
               op_sel_d = data_in[OPW-1:0];
               if (op_legal) begin
                  cnt_d   = CntInit;
                  state_d = StExec;
               end else begin
                  // Illegal opcode skips the datapath entirely.
                  err_d    = 1'b1;
                  result_d = '0;
                  state_d  = StDone;
               end
            end
         end
         StExec: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CntW'(1);
            end else begin
               result_d       = alu_y;
               result_valid_d = 1'b1;
               state_d        = StDone;
            end
         end
         StDone: begin
            if (ld) begin
               result_valid_d = 1'b0;
               err_d          = 1'b0;
               state_d        = StA;
            end
         end
         default: begin
            result_valid_d = 1'b0;
            err_d          = 1'b0;
            state_d        = StA;
         end
      endcase
   end

   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign op_sel       = op_sel_q;
   assign op_valid     = (state_q == StExec);
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign err          = err_q;
   assign state        = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (LAT=1 and LAT=3) driven by directed and
// random load events, checked against a transaction-level model of the sequencer.
module tb_alu_op_sequencer;

   logic       clk;
   logic       rst;
   logic [5:0] din;
   logic       ld_v;
   bit         sel;

   logic       load1, load3;
   logic [5:0] alu_y1, alu_y3;
   logic [5:0] op_a1, op_b1, res1, op_a3, op_b3, res3;
   logic [2:0] op_sel1, st1, op_sel3, st3;
   logic       ov1, rv1, err1, ov3, rv3, err3;

   logic [5:0] a_s, b_s, res_s;
   logic [2:0] opsel_s, st_s;
   logic       ov_s, rv_s, err_s;

   logic [5:0] p0, p1;
   int         ov_cnt [2];

   int         n_chk, n_bad;
   int         m_st  [2];
   logic [5:0] m_a   [2];
   logic [5:0] m_b   [2];
   logic [5:0] m_res [2];
   logic [2:0] m_op  [2];
   bit         m_rv  [2];
   bit         m_err [2];
   int         m_ov  [2];

   alu_op_sequencer #(.WIDTH(6), .OPW(3), .NUM_OPS(5), .LAT(1)) dut1 (
      .clk(clk), .rst(rst), .data_in(din), .load(load1), .alu_y(alu_y1),
      .op_a(op_a1), .op_b(op_b1), .op_sel(op_sel1), .op_valid(ov1),
      .result(res1), .result_valid(rv1), .err(err1), .state(st1)
   );

   alu_op_sequencer #(.WIDTH(6), .OPW(3), .NUM_OPS(5), .LAT(3)) dut3 (
      .clk(clk), .rst(rst), .data_in(din), .load(load3), .alu_y(alu_y3),
      .op_a(op_a3), .op_b(op_b3), .op_sel(op_sel3), .op_valid(ov3),
      .result(res3), .result_valid(rv3), .err(err3), .state(st3)
   );

   function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [5:0] a,
                                        input logic [5:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return a ^ b;
         default: return 6'd0;
      endcase
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign load1   = ld_v & ~sel;
   assign load3   = ld_v & sel;
   assign alu_y1  = alu_f(op_sel1, op_a1, op_b1);
   assign alu_y3  = p1;
   assign a_s     = sel ? op_a3 : op_a1;
   assign b_s     = sel ? op_b3 : op_b1;
   assign res_s   = sel ? res3 : res1;
   assign opsel_s = sel ? op_sel3 : op_sel1;
   assign st_s    = sel ? st3 : st1;
   assign ov_s    = sel ? ov3 : ov1;
   assign rv_s    = sel ? rv3 : rv1;
   assign err_s   = sel ? err3 : err1;

   // Three-cycle datapath: only valid results enter the pipe.
   always @(posedge clk) begin
      p0 <= ov3 ? alu_f(op_sel3, op_a3, op_b3) : 6'd0;
      p1 <= p0;
   end

   always @(negedge clk) begin
      if (ov1) ov_cnt[0] <= ov_cnt[0] + 1;
      if (ov3) ov_cnt[1] <= ov_cnt[1] + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string t);
      int s;
      s = sel ? 1 : 0;
      check($sformatf("%s.state", t), 32'(st_s), 32'(m_st[s]));
      check($sformatf("%s.op_a", t), 32'(a_s), 32'(m_a[s]));
      check($sformatf("%s.op_b", t), 32'(b_s), 32'(m_b[s]));
      check($sformatf("%s.op_sel", t), 32'(opsel_s), 32'(m_op[s]));
      check($sformatf("%s.result", t), 32'(res_s), 32'(m_res[s]));
      check($sformatf("%s.rv", t), 32'(rv_s), 32'(m_rv[s]));
      check($sformatf("%s.err", t), 32'(err_s), 32'(m_err[s]));
      check($sformatf("%s.op_valid", t), 32'(ov_s), 32'd0);
      check($sformatf("%s.ov_cycles", t), 32'(ov_cnt[s]), 32'(m_ov[s]));
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_st[s]  = 0;
         m_a[s]   = '0;
         m_b[s]   = '0;
         m_res[s] = '0;
         m_op[s]  = '0;
         m_rv[s]  = 1'b0;
         m_err[s] = 1'b0;
      end
   endtask

   task automatic drive_pulse(input logic [5:0] d, input int hold);
      @(posedge clk);
      #1;
      din  = d;
      ld_v = 1'b1;
      repeat (hold) @(posedge clk);
      #1 ld_v = 1'b0;
   endtask

   // One load event as seen by the selected sequencer; EXEC is folded into the event.
   task automatic load_evt(input logic [5:0] d, input int hold);
      int s;
      s = sel ? 1 : 0;
      case (m_st[s])
         0: begin m_a[s] = d; m_st[s] = 1; end
         1: begin m_b[s] = d; m_st[s] = 2; end
         2: begin
            m_op[s] = d[2:0];
            m_st[s] = 4;
            if (d[2:0] < 3'd5) begin
               m_res[s] = alu_f(d[2:0], m_a[s], m_b[s]);
               m_rv[s]  = 1'b1;
               m_ov[s]  = m_ov[s] + (s == 1 ? 3 : 1);
            end else begin
               m_res[s] = '0;
               m_err[s] = 1'b1;
            end
         end
         default: begin m_rv[s] = 1'b0; m_err[s] = 1'b0; m_st[s] = 0; end
      endcase
      drive_pulse(d, hold);
   endtask

   task automatic settle();
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic op_timing(input logic [5:0] d);
      int lat;
      bit legal;
      lat   = sel ? 3 : 1;
      legal = (d[2:0] < 3'd5);
      load_evt(d, 1);
      if (legal) begin
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("exec%0d.op_valid", i), 32'(ov_s), 32'd1);
            check($sformatf("exec%0d.rv", i), 32'(rv_s), 32'd0);
         end
      end
      @(negedge clk);
      #1;
      check("done.state", 32'(st_s), 32'd4);
      check("done.op_valid", 32'(ov_s), 32'd0);
      check("done.rv", 32'(rv_s), 32'(legal));
      check("done.err", 32'(err_s), 32'(!legal));
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      m_ov[0] = 0;
      m_ov[1] = 0;
      ov_cnt[0] = 0;
      ov_cnt[1] = 0;
      din  = '0;
      ld_v = 1'b0;
      sel  = 1'b0;
      rst  = 1'b0;
      model_reset();
      #1 rst = 1'b1;
      @(negedge clk);
      #1;
      check_all("rst_l1");
      sel = 1'b1;
      #1;
      check_all("rst_l3");
      @(negedge clk);
      rst = 1'b0;

      // Nominal OR on LAT=1, then re-arm.
      sel = 1'b0;
      load_evt(6'b101010, 1); settle(); check_all("or_a");
      load_evt(6'b010101, 1); settle(); check_all("or_b");
      op_timing(6'd1);        settle(); check_all("or_done");
      check("or_result", 32'(res_s), 32'd63);
      load_evt(6'd17, 1);     settle(); check_all("rearm");

      // Held button only loads once.
      load_evt(6'd9, 10);     settle(); check_all("held");
      load_evt(6'd3, 1);      settle(); check_all("held_b");
      op_timing(6'd6);        settle(); check_all("illegal");
      load_evt(6'd0, 1);      settle(); check_all("ill_rearm");

      // LAT=3 ADD, then again with a load pulse landing inside EXEC.
      sel = 1'b1;
      load_evt(6'd20, 1);     settle(); check_all("add_a");
      load_evt(6'd22, 1);     settle(); check_all("add_b");
      op_timing(6'd2);        settle(); check_all("add_done");
      check("add_result", 32'(res_s), 32'd42);
      load_evt(6'd0, 1);      settle();
      load_evt(6'd7, 1);      settle();
      load_evt(6'd8, 1);      settle();
      load_evt(6'd2, 1);
      drive_pulse(6'h3f, 1);
      settle(); check_all("exec_ignore");

      // Asynchronous reset in the second EXEC cycle.
      load_evt(6'd0, 1);      settle();
      load_evt(6'd11, 1);     settle();
      load_evt(6'd12, 1);     settle();
      drive_pulse(6'd3, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      m_ov[1] = m_ov[1] + 1;
      model_reset();
      #1;
      check_all("rst_exec");
      @(negedge clk);
      rst = 1'b0;
      settle(); check_all("rst_after");
      load_evt(6'd20, 1);     settle();
      load_evt(6'd22, 1);     settle();
      op_timing(6'd2);        settle(); check_all("post_rst");

      // Random events on both instances.
      for (int n = 0; n < 200; n++) begin
         sel = ($urandom_range(0, 1) == 1);
         load_evt(6'($urandom), int'($urandom_range(1, 4)));
         settle();
         check_all($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
